ram_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port data RAM. Requester 0 is the datapath load/store path; requester 1 is the debug/loader port. The block grants the RAM to one requester at a time, drives the RAM enable, read/write, address and write-data lines for exactly one access cycle, and returns registered read data with a one-cycle completion pulse. Arbitration is round-robin, or fixed-priority with a starvation guard, selected by parameter.

---
 rtl/ram_arbiter.sv | 86 ++++++++
 tb/tb_ram_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester single-port RAM arbiter/sequencer (round-robin or fixed priority with starvation guard)
// Ports: clk, reset (async, active-low); requester N: reqN/rwN/addrN/wdataN in, doneN/rdataN out;
// RAM side: ram_en/ram_rw/ram_addr/ram_wdata out, ram_rdata in (combinational); busy is high during ACCESS.
module ram_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int PRIO_FIXED = 0,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          rw0,
  input  logic          rw1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          ram_en,
  output logic          ram_rw,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state;
  logic owner, last, cmd_rw, e0, e1, win1;
  logic [3:0] starve;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  // a requester is ignored in the cycle its done pulses
  always_comb begin
    e0 = req0 & ~done0;
    e1 = req1 & ~done1;
    win1 = e1 & (~e0 | ((PRIO_FIXED != 0) ? (starve == SMAX) : ~last));
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      owner <= 1'b0;
      last <= 1'b1;
      starve <= '0;
      cmd_rw <= 1'b0;
      cmd_addr <= '0;
      cmd_wdata <= '0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      if (state == IDLE) begin
        if (e0 | e1) begin
          state <= ACCESS;
          owner <= win1;
          last <= win1;
          cmd_rw <= win1 ? rw1 : rw0;
          cmd_addr <= win1 ? addr1 : addr0;
          cmd_wdata <= win1 ? wdata1 : wdata0;
          // counts consecutive lost arbitrations of requester 1, saturating
          starve <= (e1 & ~win1) ? ((starve == SMAX) ? starve : starve + 4'd1) : 4'd0;
        end
      end else begin
        state <= IDLE;
        done0 <= ~owner;
        done1 <= owner;
        if (!cmd_rw && !owner) rdata0 <= ram_rdata;
        if (!cmd_rw && owner) rdata1 <= ram_rdata;
      end
    end
  always_comb begin
    ram_en = (state == ACCESS);
    busy = (state == ACCESS);
    ram_rw = cmd_rw;
    ram_addr = cmd_addr;
    ram_wdata = cmd_wdata;
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter (round-robin and fixed-priority instances)
module tb_ram_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;
  logic r_req0 = 0, r_req1 = 0, r_rw0 = 0, r_rw1 = 0;
  logic [AW-1:0] r_addr0 = 0, r_addr1 = 0;
  logic [DW-1:0] r_wdata0 = 0, r_wdata1 = 0;
  logic r_done0, r_done1, r_ram_en, r_ram_rw, r_busy;
  logic [DW-1:0] r_rdata0, r_rdata1, r_ram_wdata, r_ram_rdata;
  logic [AW-1:0] r_ram_addr;
  logic f_req0 = 0, f_req1 = 0, f_rw0 = 0, f_rw1 = 0;
  logic [AW-1:0] f_addr0 = 16'h0010, f_addr1 = 16'h0020;
  logic [DW-1:0] f_wdata0 = 0, f_wdata1 = 0;
  logic f_done0, f_done1, f_ram_en, f_ram_rw, f_busy;
  logic [DW-1:0] f_rdata0, f_rdata1, f_ram_wdata, f_ram_rdata;
  logic [AW-1:0] f_ram_addr;
  logic pre_we = 0;
  logic [7:0] pre_a = 0;
  logic [DW-1:0] pre_d = 0;
  logic [DW-1:0] r_mem [256];
  logic [DW-1:0] f_mem [256];
  assign r_ram_rdata = r_mem[r_ram_addr[7:0]];
  assign f_ram_rdata = f_mem[f_ram_addr[7:0]];
  always @(posedge clk) begin
    if (pre_we) r_mem[pre_a] <= pre_d;
    else if (r_ram_en && r_ram_rw) r_mem[r_ram_addr[7:0]] <= r_ram_wdata;
    if (f_ram_en && f_ram_rw) f_mem[f_ram_addr[7:0]] <= f_ram_wdata;
  end
  ram_arbiter #(.AW(AW), .DW(DW), .PRIO_FIXED(0), .STARVE_MAX(4)) u_rr (
    .clk(clk), .reset(reset),
    .req0(r_req0), .req1(r_req1), .rw0(r_rw0), .rw1(r_rw1),
    .addr0(r_addr0), .addr1(r_addr1), .wdata0(r_wdata0), .wdata1(r_wdata1),
    .done0(r_done0), .done1(r_done1), .rdata0(r_rdata0), .rdata1(r_rdata1),
    .ram_en(r_ram_en), .ram_rw(r_ram_rw), .ram_addr(r_ram_addr),
    .ram_wdata(r_ram_wdata), .ram_rdata(r_ram_rdata), .busy(r_busy)
  );
  ram_arbiter #(.AW(AW), .DW(DW), .PRIO_FIXED(1), .STARVE_MAX(3)) u_fp (
    .clk(clk), .reset(reset),
    .req0(f_req0), .req1(f_req1), .rw0(f_rw0), .rw1(f_rw1),
    .addr0(f_addr0), .addr1(f_addr1), .wdata0(f_wdata0), .wdata1(f_wdata1),
    .done0(f_done0), .done1(f_done1), .rdata0(f_rdata0), .rdata1(f_rdata1),
    .ram_en(f_ram_en), .ram_rw(f_ram_rw), .ram_addr(f_ram_addr),
    .ram_wdata(f_ram_wdata), .ram_rdata(f_ram_rdata), .busy(f_busy)
  );

  task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pre_a = a;
    pre_d = d;
    pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({r_ram_en, r_ram_rw, r_ram_addr, r_ram_wdata, r_done0, r_done1, r_rdata0, r_rdata1, r_busy} !== 69'd0) begin
      n_bad++;
      $display("FAIL reset_rr got en=%b rw=%b addr=%h wd=%h d0=%b d1=%b rd0=%h rd1=%h busy=%b want all 0",
               r_ram_en, r_ram_rw, r_ram_addr, r_ram_wdata, r_done0, r_done1, r_rdata0, r_rdata1, r_busy);
    end
    n_cmp++;
    if ({f_ram_en, f_ram_addr, f_done0, f_done1, f_busy} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_fp got en=%b addr=%h d0=%b d1=%b busy=%b want all 0", f_ram_en, f_ram_addr, f_done0, f_done1, f_busy);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({r_ram_en, r_busy, r_done0, r_done1} !== 4'b0000) begin
      n_bad++;
      $display("FAIL idle_after_reset got en=%b busy=%b d0=%b d1=%b want 0", r_ram_en, r_busy, r_done0, r_done1);
    end
  endtask

  task automatic test_fixed_prio();
    logic [AW-1:0] exp_addr;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 f_req0 = 1'b1;
      f_req1 = 1'b1;
      @(posedge clk);
      #1 f_req0 = 1'b0;
      f_req1 = 1'b0;
      exp_addr = (i == 3) ? 16'h0020 : 16'h0010;
      @(negedge clk);
      n_cmp++;
      if ({f_ram_en, f_ram_addr} !== {1'b1, exp_addr}) begin
        n_bad++;
        $display("FAIL fixed_grant_%0d got en=%b addr=%h want en=1 addr=%h", i, f_ram_en, f_ram_addr, exp_addr);
      end
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({f_done0, f_done1} !== ((i == 3) ? 2'b01 : 2'b10)) begin
        n_bad++;
        $display("FAIL fixed_done_%0d got d0=%b d1=%b want winner %0d", i, f_done0, f_done1, (i == 3) ? 1 : 0);
      end
    end
  endtask

  task automatic test_single_read();
    preload(8'h10, 16'hBEEF);
    @(posedge clk);
    #1 r_req0 = 1'b1;
    r_rw0 = 1'b0;
    r_addr0 = 16'h0010;
    @(posedge clk);
    #1 r_req0 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({r_ram_en, r_ram_rw, r_ram_addr, r_busy, r_done0, r_done1} !== {1'b1, 1'b0, 16'h0010, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL read_access got en=%b rw=%b addr=%h busy=%b d0=%b d1=%b want 1 0 0010 1 0 0",
               r_ram_en, r_ram_rw, r_ram_addr, r_busy, r_done0, r_done1);
    end
    @(negedge clk);
    n_cmp++;
    if ({r_ram_en, r_busy, r_done0, r_done1, r_rdata0} !== {1'b0, 1'b0, 1'b1, 1'b0, 16'hBEEF}) begin
      n_bad++;
      $display("FAIL read_done got en=%b busy=%b d0=%b d1=%b rd0=%h want 0 0 1 0 beef", r_ram_en, r_busy, r_done0, r_done1, r_rdata0);
    end
    @(negedge clk);
    n_cmp++;
    if ({r_ram_en, r_done0, r_ram_addr, r_rdata0} !== {1'b0, 1'b0, 16'h0010, 16'hBEEF}) begin
      n_bad++;
      $display("FAIL read_after got en=%b d0=%b addr=%h rd0=%h want 0 0 0010 beef", r_ram_en, r_done0, r_ram_addr, r_rdata0);
    end
  endtask

  task automatic test_write_readback();
    @(posedge clk);
    #1 r_req1 = 1'b1;
    r_rw1 = 1'b1;
    r_addr1 = 16'h0020;
    r_wdata1 = 16'h1234;
    @(posedge clk);
    #1 r_req1 = 1'b0;
    r_wdata1 = 16'hFFFF;
    @(negedge clk);
    n_cmp++;
    if ({r_ram_en, r_ram_rw, r_ram_addr, r_ram_wdata} !== {1'b1, 1'b1, 16'h0020, 16'h1234}) begin
      n_bad++;
      $display("FAIL write_access got en=%b rw=%b addr=%h wd=%h want 1 1 0020 1234", r_ram_en, r_ram_rw, r_ram_addr, r_ram_wdata);
    end
    @(negedge clk);
    n_cmp++;
    if ({r_done1, r_done0, r_rdata1} !== {1'b1, 1'b0, 16'h0000}) begin
      n_bad++;
      $display("FAIL write_done got d1=%b d0=%b rd1=%h want 1 0 0000", r_done1, r_done0, r_rdata1);
    end
    @(posedge clk);
    #1 r_req1 = 1'b1;
    r_rw1 = 1'b0;
    @(posedge clk);
    #1 r_req1 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({r_ram_en, r_ram_rw, r_ram_addr} !== {1'b1, 1'b0, 16'h0020}) begin
      n_bad++;
      $display("FAIL readback_access got en=%b rw=%b addr=%h want 1 0 0020", r_ram_en, r_ram_rw, r_ram_addr);
    end
    @(negedge clk);
    n_cmp++;
    if ({r_done1, r_rdata1, r_rdata0} !== {1'b1, 16'h1234, 16'hBEEF}) begin
      n_bad++;
      $display("FAIL readback_done got d1=%b rd1=%h rd0=%h want 1 1234 beef", r_done1, r_rdata1, r_rdata0);
    end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] exp_addr;
    @(posedge clk);
    #1 r_req0 = 1'b1;
    r_rw0 = 1'b0;
    r_addr0 = 16'h0010;
    r_req1 = 1'b1;
    r_rw1 = 1'b0;
    r_addr1 = 16'h0020;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      exp_addr = (i % 4 == 1 || i % 4 == 2) ? 16'h0010 : 16'h0020;
      n_cmp++;
      if ({r_busy, r_ram_en, r_done0, r_done1, r_ram_addr} !== {i[0], i[0], i % 4 == 2, i % 4 == 0, exp_addr}) begin
        n_bad++;
        $display("FAIL rr_cycle_%0d got busy=%b en=%b d0=%b d1=%b addr=%h want busy=%b d0=%b d1=%b addr=%h",
                 i, r_busy, r_ram_en, r_done0, r_done1, r_ram_addr, i[0], i % 4 == 2, i % 4 == 0, exp_addr);
      end
    end
    r_req0 = 1'b0;
    r_req1 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({r_busy, r_rdata0, r_rdata1} !== {1'b0, 16'hBEEF, 16'h1234}) begin
      n_bad++;
      $display("FAIL rr_end got busy=%b rd0=%h rd1=%h want 0 beef 1234", r_busy, r_rdata0, r_rdata1);
    end
  endtask

  task automatic test_input_change();
    preload(8'h05, 16'h0505);
    preload(8'h06, 16'h0606);
    @(posedge clk);
    #1 r_req0 = 1'b1;
    r_rw0 = 1'b0;
    r_addr0 = 16'h0005;
    @(posedge clk);
    #1 r_req0 = 1'b0;
    r_addr0 = 16'h0006;
    @(negedge clk);
    n_cmp++;
    if ({r_ram_en, r_ram_addr} !== {1'b1, 16'h0005}) begin
      n_bad++;
      $display("FAIL change_addr got en=%b addr=%h want 1 0005", r_ram_en, r_ram_addr);
    end
    @(negedge clk);
    n_cmp++;
    if ({r_done0, r_rdata0} !== {1'b1, 16'h0505}) begin
      n_bad++;
      $display("FAIL change_data got d0=%b rd0=%h want 1 0505", r_done0, r_rdata0);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1 r_req1 = 1'b1;
    r_rw1 = 1'b0;
    r_addr1 = 16'h0010;
    @(posedge clk);
    #1 r_req1 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (r_ram_en !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_access got en=%b want 1", r_ram_en);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({r_ram_en, r_ram_rw, r_ram_addr, r_ram_wdata, r_done0, r_done1, r_rdata0, r_rdata1, r_busy} !== 69'd0) begin
      n_bad++;
      $display("FAIL mid_reset_async got en=%b addr=%h d1=%b rd0=%h rd1=%h busy=%b want all 0",
               r_ram_en, r_ram_addr, r_done1, r_rdata0, r_rdata1, r_busy);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({r_ram_en, r_done0, r_done1, r_rdata1} !== {3'b000, 16'h0000}) begin
      n_bad++;
      $display("FAIL mid_reset_nodone got en=%b d0=%b d1=%b rd1=%h want 0 0 0 0000", r_ram_en, r_done0, r_done1, r_rdata1);
    end
    @(posedge clk);
    #1 r_req1 = 1'b1;
    r_addr1 = 16'h0020;
    @(posedge clk);
    #1 r_req1 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({r_ram_en, r_ram_addr} !== {1'b1, 16'h0020}) begin
      n_bad++;
      $display("FAIL post_reset_access got en=%b addr=%h want 1 0020", r_ram_en, r_ram_addr);
    end
    @(negedge clk);
    n_cmp++;
    if ({r_done1, r_rdata1} !== {1'b1, 16'h1234}) begin
      n_bad++;
      $display("FAIL post_reset_read got d1=%b rd1=%h want 1 1234", r_done1, r_rdata1);
    end
  endtask

  initial begin
    test_reset();
    test_fixed_prio();
    test_single_read();
    test_write_readback();
    test_round_robin();
    test_input_change();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
